collision_engine: RTL



---
 rtl/collision_engine_pkg.sv | 20 ++
 rtl/collision_engine_pos_match.sv | 16 +
 rtl/collision_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/collision_engine_pkg.sv
// Shared constants for the collision engine: FSM encoding and default sizing.
// Latency: n/a (package only).
// Backpressure: n/a.
package collision_engine_pkg;

    localparam int DEF_NUM_SEG  = 7;
    localparam int DEF_COORD_W  = 4;
    localparam int DEF_COOLDOWN = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SNAP   = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Width of a segment index; a single-segment dragon still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/collision_engine_pos_match.sv
// Enabled tile-position equality compare.
// Latency: combinational.
// Backpressure: none.
module pos_match #(
    parameter int POS_W = 8
) (
    input  logic             en,
    input  logic [POS_W-1:0] a,
    input  logic [POS_W-1:0] b,
    output logic             match
);

    // A disabled target (invisible segment or sword) never matches.
    assign match = en && (a == b);

endmodule

// File: rtl/collision_engine.sv
// Per-frame dragon collision scan: player, sword and sheep against each segment.
// Latency: done and updated flags NUM_SEG+2 cycles after frame_start.
// Backpressure: none; a frame_start during a scan restarts it from a fresh snapshot.
module collision_engine
    import collision_engine_pkg::*;
#(
    parameter int NUM_SEG  = DEF_NUM_SEG,
    parameter int COORD_W  = DEF_COORD_W,
    parameter int COOLDOWN = DEF_COOLDOWN,
    localparam int POS_W   = 2 * COORD_W,
    localparam int IDX_W   = idx_width(NUM_SEG)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [POS_W-1:0]         player_pos,
    input  logic [POS_W-1:0]         sword_pos,
    input  logic                     sword_active,
    input  logic [POS_W-1:0]         sheep_pos,
    input  logic [NUM_SEG-1:0]       seg_active,
    input  logic [NUM_SEG*POS_W-1:0] seg_pos,
    output logic                     player_hit,
    output logic                     sword_hit,
    output logic                     sheep_hit,
    output logic                     player_hit_evt,
    output logic                     sword_hit_evt,
    output logic                     sheep_hit_evt,
    output logic [IDX_W-1:0]         sword_seg_idx,
    output logic                     busy,
    output logic                     done
);

    localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(NUM_SEG - 1);
    localparam logic [3:0]       CD_LOAD  = 4'(COOLDOWN);

    logic [1:0]               state;
    logic [IDX_W-1:0]         cnt;

    logic [POS_W-1:0]         player_q;
    logic [POS_W-1:0]         sword_q;
    logic [POS_W-1:0]         sheep_q;
    logic                     sword_act_q;
    logic [NUM_SEG-1:0]       seg_act_q;
    logic [NUM_SEG*POS_W-1:0] seg_pos_q;

    logic                     acc_player;
    logic                     acc_sword;
    logic                     acc_sheep;
    logic [IDX_W-1:0]         acc_idx;

    logic                     player_nx;
    logic                     sword_nx;
    logic                     sheep_nx;
    logic [IDX_W-1:0]         idx_nx;

    logic [3:0]               cd_cnt;

    logic [POS_W-1:0]         cur_pos;
    logic                     cur_act;
    logic                     last_seg;
    logic                     commit_go;
    logic                     m_player;
    logic                     m_sword;
    logic                     m_sheep;

    assign cur_pos   = seg_pos_q[cnt*POS_W +: POS_W];
    assign cur_act   = seg_act_q[cnt];
    assign last_seg  = (cnt == LAST_SEG);
    // The final scan cycle commits unless a new frame_start aborts it.
    assign commit_go = (state == ST_SCAN) && last_seg && !frame_start;

    assign busy = (state == ST_SNAP) || (state == ST_SCAN);
    assign done = (state == ST_COMMIT);

    pos_match #(.POS_W(POS_W)) u_match_player (
        .en    (cur_act),
        .a     (cur_pos),
        .b     (player_q),
        .match (m_player)
    );

    pos_match #(.POS_W(POS_W)) u_match_sword (
        .en    (cur_act && sword_act_q),
        .a     (cur_pos),
        .b     (sword_q),
        .match (m_sword)
    );

    // Only the head can eat the sheep.
    pos_match #(.POS_W(POS_W)) u_match_sheep (
        .en    (cur_act && (cnt == '0)),
        .a     (cur_pos),
        .b     (sheep_q),
        .match (m_sheep)
    );

    // Fold the current segment into the running flags; keep the first sword index.
    always_comb begin
        player_nx = acc_player | m_player;
        sword_nx  = acc_sword  | m_sword;
        sheep_nx  = acc_sheep  | m_sheep;
        idx_nx    = acc_idx;
        if (m_sword && !acc_sword) begin
            idx_nx = cnt;
        end
    end

    // Frame sequencing and segment counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) state <= ST_SNAP;
                end
                ST_SNAP: begin
                    cnt   <= '0;
                    state <= frame_start ? ST_SNAP : ST_SCAN;
                end
                ST_SCAN: begin
                    if (frame_start) begin
                        state <= ST_SNAP;
                    end else if (last_seg) begin
                        state <= ST_COMMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= frame_start ? ST_SNAP : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the scene once per frame so mid-scan input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            player_q    <= '0;
            sword_q     <= '0;
            sheep_q     <= '0;
            sword_act_q <= 1'b0;
            seg_act_q   <= '0;
            seg_pos_q   <= '0;
        end else if (state == ST_SNAP) begin
            player_q    <= player_pos;
            sword_q     <= sword_pos;
            sheep_q     <= sheep_pos;
            sword_act_q <= sword_active;
            seg_act_q   <= seg_active;
            seg_pos_q   <= seg_pos;
        end
    end

    // Accumulators: cleared at every snapshot, so an aborted scan leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_player <= 1'b0;
            acc_sword  <= 1'b0;
            acc_sheep  <= 1'b0;
            acc_idx    <= '0;
        end else if (state == ST_SNAP) begin
            acc_player <= 1'b0;
            acc_sword  <= 1'b0;
            acc_sheep  <= 1'b0;
            acc_idx    <= '0;
        end else if (state == ST_SCAN) begin
            acc_player <= player_nx;
            acc_sword  <= sword_nx;
            acc_sheep  <= sheep_nx;
            acc_idx    <= idx_nx;
        end
    end

    // Publish flags, edge events and player cooldown; visible during the COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            player_hit     <= 1'b0;
            sword_hit      <= 1'b0;
            sheep_hit      <= 1'b0;
            sword_seg_idx  <= '0;
            player_hit_evt <= 1'b0;
            sword_hit_evt  <= 1'b0;
            sheep_hit_evt  <= 1'b0;
            cd_cnt         <= '0;
        end else begin
            player_hit_evt <= 1'b0;
            sword_hit_evt  <= 1'b0;
            sheep_hit_evt  <= 1'b0;
            if (commit_go) begin
                player_hit    <= player_nx;
                sword_hit     <= sword_nx;
                sheep_hit     <= sheep_nx;
                sword_seg_idx <= sword_nx ? idx_nx : '0;
                // Current flag registers still hold the previous frame's result here.
                sword_hit_evt <= sword_nx && !sword_hit;
                sheep_hit_evt <= sheep_nx && !sheep_hit;
                if (player_nx && !player_hit && (cd_cnt == '0)) begin
                    player_hit_evt <= 1'b1;
                    cd_cnt         <= CD_LOAD;
                end else if (cd_cnt != '0) begin
                    cd_cnt <= cd_cnt - 4'd1;
                end
            end
        end
    end

endmodule
